alu_seq: RTL and testbench

Parametrised multi-cycle arithmetic unit for the 65C816 core and the SNES CPU-side math registers. It covers:
- single-cycle binary add/subtract;
- iterative decimal (BCD) add/subtract, one nibble per cycle, for any width;
- iterative unsigned multiply and divide.

The block is the next-generation arithmetic path: it adds width genericity, multiply/divide, and a START/BUSY/DONE handshake. It sits beside the combinational ALU and is driven by the microcode/register-file sequencer.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the microcode sequencer and the multi-cycle ALU.
// The sequencer owns the request side; the ALU owns BUSY, DONE, results and flags.
interface alu_seq_if #(
  parameter int W = 16
);
  logic         START;
  logic [2:0]   OP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CI;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RES_LO;
  logic [W-1:0] RES_HI;
  logic         CO;
  logic         VO;
  logic         ZO;
  logic         NO;

  modport master (
    output START, OP, A, B, CI,
    input  BUSY, DONE, RES_LO, RES_HI, CO, VO, ZO, NO
  );

  modport slave (
    input  START, OP, A, B, CI,
    output BUSY, DONE, RES_LO, RES_HI, CO, VO, ZO, NO
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: binary add/sub, nibble-serial BCD add/sub, shift-add multiply and
// restoring divide behind a START/BUSY/DONE handshake. Outputs change only on DONE.
module alu_seq #(
  parameter int W = 16
) (
  input  logic     CLK,
  input  logic     RST,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam int W1 = W + 1;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_MUL     = 3'b010;
  localparam logic [2:0] OP_DIV     = 3'b011;
  localparam logic [2:0] OP_ADD_BCD = 3'b100;
  localparam logic [2:0] OP_SUB_BCD = 3'b101;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  res_lo_q, res_lo_d;
  logic [W-1:0]  res_hi_q, res_hi_d;
  logic          co_q, co_d;
  logic          vo_q, vo_d;
  logic          zo_q, zo_d;
  logic          no_q, no_d;

  logic [W-1:0]  add_b;
  logic [W:0]    bin_sum;
  logic          bin_vo;
  logic [4:0]    s_raw;
  logic [4:0]    d_raw;
  logic [3:0]    bcd_nib;
  logic          bcd_c;
  logic          bcd_vo;
  logic [W:0]    mul_sum;
  logic [W:0]    div_sh;
  logic          div_ge;
  logic [W-1:0]  div_rem;
  logic [W-1:0]  fin_lo;
  logic [W-1:0]  fin_hi;
  logic          fin_co;
  logic          fin_vo;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    co_d     = co_q;
    vo_d     = vo_q;
    zo_d     = zo_q;
    no_d     = no_q;
    fin_lo   = '0;
    fin_hi   = '0;
    fin_co   = 1'b0;
    fin_vo   = 1'b0;

    // SUB is A + ~B + CI, so CI=1 means "no borrow".
    add_b   = (op_q == OP_SUB) ? ~b_q : b_q;
    bin_sum = {1'b0, a_q} + {1'b0, add_b} + W1'(c_q);
    bin_vo  = (a_q[W-1] == add_b[W-1]) && (bin_sum[W-1] != a_q[W-1]);

    // The current BCD digit always sits in the low nibble; operands shift right each step.
    s_raw = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_q};
    d_raw = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, ~c_q};
    if (op_q == OP_SUB_BCD) begin
      bcd_c   = ~d_raw[4];
      bcd_nib = d_raw[4] ? d_raw[3:0] + 4'd10 : d_raw[3:0];
      bcd_vo  = (a_q[3] != b_q[3]) && (d_raw[3] != a_q[3]);
    end else begin
      bcd_c   = (s_raw > 5'd9);
      bcd_nib = bcd_c ? s_raw[3:0] + 4'd6 : s_raw[3:0];
      bcd_vo  = (a_q[3] == b_q[3]) && (s_raw[3] != a_q[3]);
    end

    // Multiply keeps the running high half in acc and retires multiplier bits out of b.
    mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {W1{1'b0}});
    div_sh  = {acc_q, a_q[W-1]};
    div_ge  = (div_sh >= {1'b0, b_q});
    div_rem = div_ge ? W'(div_sh - {1'b0, b_q}) : div_sh[W-1:0];

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          op_d    = bus.OP;
          a_d     = bus.A;
          b_d     = bus.B;
          c_d     = bus.CI;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
          case (bus.OP)
            OP_MUL, OP_DIV:         cnt_d = CW'(W - 1);
            OP_ADD_BCD, OP_SUB_BCD: cnt_d = CW'(W / 4 - 1);
            default:                cnt_d = '0;
          endcase
        end
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        case (op_q)
          OP_ADD, OP_SUB: begin
            fin_lo = bin_sum[W-1:0];
            fin_co = bin_sum[W];
            fin_vo = bin_vo;
          end
          OP_ADD_BCD, OP_SUB_BCD: begin
            acc_d  = {bcd_nib, acc_q[W-1:4]};
            a_d    = a_q >> 4;
            b_d    = b_q >> 4;
            c_d    = bcd_c;
            fin_lo = acc_d;
            fin_co = bcd_c;
            fin_vo = bcd_vo;
          end
          OP_MUL: begin
            acc_d  = mul_sum[W:1];
            b_d    = {mul_sum[0], b_q[W-1:1]};
            fin_lo = b_d;
            fin_hi = acc_d;
          end
          OP_DIV: begin
            // A zero divisor falls out naturally as quotient all-ones, remainder A.
            acc_d  = div_rem;
            a_d    = {a_q[W-2:0], div_ge};
            fin_lo = a_d;
            fin_hi = acc_d;
            fin_vo = (b_q == '0);
          end
          default: begin
            fin_lo = a_q;
            fin_co = c_q;
          end
        endcase
        if (cnt_q == '0) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          res_lo_d = fin_lo;
          res_hi_d = fin_hi;
          co_d     = fin_co;
          vo_d     = fin_vo;
          zo_d     = (op_q == OP_MUL) ? ({fin_hi, fin_lo} == '0) : (fin_lo == '0);
          no_d     = (op_q == OP_MUL) ? fin_hi[W-1] : fin_lo[W-1];
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      co_q     <= 1'b0;
      vo_q     <= 1'b0;
      zo_q     <= 1'b0;
      no_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      co_q     <= co_d;
      vo_q     <= vo_d;
      zo_q     <= zo_d;
      no_q     <= no_d;
    end
  end

  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RES_LO = res_lo_q;
  assign bus.RES_HI = res_hi_q;
  assign bus.CO     = co_q;
  assign bus.VO     = vo_q;
  assign bus.ZO     = zo_q;
  assign bus.NO     = no_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq (W=16 and W=8) against an arithmetic reference model.
module tb_alu_seq;
  logic CLK;
  logic RST;
  int   errors;
  int   checks;

  alu_seq_if #(.W(16)) if16 ();
  alu_seq_if #(.W(8))  if8 ();

  alu_seq #(.W(16)) dut16 (.CLK(CLK), .RST(RST), .bus(if16));
  alu_seq #(.W(8))  dut8  (.CLK(CLK), .RST(RST), .bus(if8));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions, with integer maths.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic ci, output logic [15:0] lo, output logic [15:0] hi,
                                output logic co, output logic vo, output logic zo,
                                output logic no, output int n);
    int s, sv, da, db, sa, sb, c;
    logic [31:0] p;
    lo = '0; hi = '0; co = 1'b0; vo = 1'b0; n = 1;
    p = 32'(a) * 32'(b);
    case (op)
      3'd0: begin
        s  = int'(a) + int'(b) + int'(ci);
        lo = s[15:0];
        co = (s > 65535);
        sv = int'($signed(a)) + int'($signed(b)) + int'(ci);
        vo = (sv > 32767) || (sv < -32768);
      end
      3'd1: begin
        s  = int'(a) + (65535 - int'(b)) + int'(ci);
        lo = s[15:0];
        co = (s > 65535);
        sv = int'($signed(a)) - int'($signed(b)) - (1 - int'(ci));
        vo = (sv > 32767) || (sv < -32768);
      end
      3'd2: begin
        lo = p[15:0];
        hi = p[31:16];
        n  = 16;
      end
      3'd3: begin
        n = 16;
        if (b == 16'd0) begin
          lo = 16'hFFFF;
          hi = a;
          vo = 1'b1;
        end else begin
          lo = 16'(int'(a) / int'(b));
          hi = 16'(int'(a) % int'(b));
        end
      end
      3'd4, 3'd5: begin
        n = 4;
        c = int'(ci);
        for (int i = 0; i < 4; i++) begin
          da = (int'(a) >> (4 * i)) & 15;
          db = (int'(b) >> (4 * i)) & 15;
          sa = (da > 7) ? da - 16 : da;
          sb = (db > 7) ? db - 16 : db;
          if (op == 3'd4) begin
            sv = sa + sb + c;
            s  = da + db + c;
            if (s > 9) begin s = s + 6; c = 1; end else c = 0;
          end else begin
            sv = sa - sb - (1 - c);
            s  = da - db - (1 - c);
            if (s < 0) begin s = s + 10; c = 0; end else c = 1;
          end
          if (i == 3) vo = (sv > 7) || (sv < -8);
          lo = lo | (16'(s & 15) << (4 * i));
        end
        co = (c != 0);
      end
      default: begin
        lo = a;
        co = ci;
      end
    endcase
    if (op == 3'd2) begin
      zo = (p == 32'd0);
      no = p[31];
    end else begin
      zo = (lo == 16'd0);
      no = lo[15];
    end
  endfunction

  // Entered and left at a falling edge; leaves while DONE is high so the next call
  // also exercises a START accepted during the DONE cycle.
  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input int poke);
    logic [15:0] e_lo, e_hi;
    logic e_co, e_vo, e_zo, e_no, got;
    int e_n, cyc;
    model(op, a, b, ci, e_lo, e_hi, e_co, e_vo, e_zo, e_no, e_n);
    if16.START = 1'b1; if16.OP = op; if16.A = a; if16.B = b; if16.CI = ci;
    @(posedge CLK); @(negedge CLK);
    if16.START = 1'b0;
    check("busy_after_accept", 32'(if16.BUSY), 32'd1);
    check("done_low_after_accept", 32'(if16.DONE), 32'd0);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge CLK); @(negedge CLK);
      cyc++;
      if (poke != 0 && cyc == poke) begin
        if16.START = 1'b1; if16.OP = 3'd0; if16.A = 16'($urandom); if16.B = 16'($urandom);
      end else begin
        if16.START = 1'b0;
      end
      got = if16.DONE;
    end
    if16.START = 1'b0;
    $display("op=%0d a=%h b=%h ci=%0d -> lo=%h hi=%h co=%0d vo=%0d zo=%0d no=%0d cycles=%0d",
             op, a, b, ci, if16.RES_LO, if16.RES_HI, if16.CO, if16.VO, if16.ZO, if16.NO, cyc);
    check("latency", 32'(cyc), 32'(e_n));
    check("busy_at_done", 32'(if16.BUSY), 32'd0);
    check("res_lo", 32'(if16.RES_LO), 32'(e_lo));
    check("res_hi", 32'(if16.RES_HI), 32'(e_hi));
    check("co", 32'(if16.CO), 32'(e_co));
    check("vo", 32'(if16.VO), 32'(e_vo));
    check("zo", 32'(if16.ZO), 32'(e_zo));
    check("no", 32'(if16.NO), 32'(e_no));
  endtask

  task automatic check_zero16(input string tag);
    check({tag, "_busy"}, 32'(if16.BUSY), 32'd0);
    check({tag, "_done"}, 32'(if16.DONE), 32'd0);
    check({tag, "_lo"}, 32'(if16.RES_LO), 32'd0);
    check({tag, "_hi"}, 32'(if16.RES_HI), 32'd0);
    check({tag, "_flags"}, 32'({if16.CO, if16.VO, if16.ZO, if16.NO}), 32'd0);
  endtask

  initial begin
    int cyc8;
    errors = 0;
    checks = 0;
    RST = 1'b1;
    if16.START = 1'b0; if16.OP = '0; if16.A = '0; if16.B = '0; if16.CI = 1'b0;
    if8.START  = 1'b0; if8.OP  = '0; if8.A  = '0; if8.B  = '0; if8.CI  = 1'b0;
    #1;
    check_zero16("reset16");
    check("reset8_busy_done", 32'({if8.BUSY, if8.DONE}), 32'd0);
    check("reset8_res", 32'({if8.RES_HI, if8.RES_LO}), 32'd0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    run16(3'd0, 16'h7FFF, 16'h0001, 1'b0, 0);
    run16(3'd4, 16'h0999, 16'h0001, 1'b0, 0);
    run16(3'd4, 16'h9999, 16'h0001, 1'b0, 0);
    run16(3'd5, 16'h1000, 16'h0001, 1'b1, 0);
    run16(3'd1, 16'h0000, 16'h0001, 1'b1, 0);
    run16(3'd2, 16'hFFFF, 16'hFFFF, 1'b0, 5);
    run16(3'd3, 16'd100, 16'd7, 1'b0, 0);
    run16(3'd6, 16'hA5C3, 16'h1111, 1'b1, 0);
    run16(3'd3, 16'h1234, 16'h0000, 1'b0, 0);

    // Reset in the middle of a multiply must clear everything immediately.
    if16.START = 1'b1; if16.OP = 3'd2; if16.A = 16'hFFFF; if16.B = 16'hFFFF;
    @(posedge CLK); @(negedge CLK);
    if16.START = 1'b0;
    repeat (7) @(negedge CLK);
    check("mul_busy_before_reset", 32'(if16.BUSY), 32'd1);
    check("held_lo_before_reset", 32'(if16.RES_LO), 32'hFFFF);
    RST = 1'b1;
    #1;
    check_zero16("midreset");
    @(negedge CLK);
    RST = 1'b0;
    run16(3'd0, 16'h0001, 16'h0002, 1'b0, 0);

    for (int k = 0; k < 60; k++) begin
      logic [2:0] rop;
      logic [15:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if (rop == 3'd4 || rop == 3'd5) begin
        ra = 16'($urandom_range(0, 9) * 4096 + $urandom_range(0, 9) * 256 +
                 $urandom_range(0, 9) * 16 + $urandom_range(0, 9));
        rb = 16'($urandom_range(0, 9) * 4096 + $urandom_range(0, 9) * 256 +
                 $urandom_range(0, 9) * 16 + $urandom_range(0, 9));
      end
      run16(rop, ra, rb, 1'($urandom_range(0, 1)), (k % 5 == 0) ? 3 : 0);
    end

    // Narrow instance: two-digit BCD add wrapping to zero.
    @(negedge CLK);
    if8.START = 1'b1; if8.OP = 3'd4; if8.A = 8'h99; if8.B = 8'h01; if8.CI = 1'b0;
    @(posedge CLK); @(negedge CLK);
    if8.START = 1'b0;
    cyc8 = 0;
    while (!if8.DONE && cyc8 < 100) begin
      @(posedge CLK); @(negedge CLK);
      cyc8++;
    end
    $display("w8 op=4 a=99 b=01 ci=0 -> lo=%h hi=%h co=%0d vo=%0d zo=%0d no=%0d cycles=%0d",
             if8.RES_LO, if8.RES_HI, if8.CO, if8.VO, if8.ZO, if8.NO, cyc8);
    check("w8_latency", 32'(cyc8), 32'd2);
    check("w8_res_lo", 32'(if8.RES_LO), 32'h00);
    check("w8_res_hi", 32'(if8.RES_HI), 32'h00);
    check("w8_co", 32'(if8.CO), 32'd1);
    check("w8_zo", 32'(if8.ZO), 32'd1);
    check("w8_vo_no", 32'({if8.VO, if8.NO}), 32'd0);
    @(negedge CLK);
    check("w8_done_pulse_width", 32'(if8.DONE), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
